alu_op_sequencer: RTL and testbench

- Instruction sequencer that drives the team's combinational 8-bit ALU as an accumulator machine.
- Accepts one instruction at a time over a valid/ready handshake and applies the ALU op to the accumulator 1..2^REP_W times.
- Latches the result and flags, then presents them on a valid/ready output handshake.
- Sits between the command source (test host / future CPU decode) and the ALU.

---
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Accumulator sequencer for the 8-bit combinational ALU. It takes one
// instruction at a time, applies the ALU op to the accumulator 1..2^REP_W
// times (or loads a constant), then presents the result on an output handshake.
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready=1
// EXEC  | one ALU iteration per cycle, ACC <= alu_result
// DONE  | result and flags held, out_valid=1 until out_ready
module alu_op_sequencer #(
   parameter int unsigned REP_W     = 3,
   parameter logic [7:0]  ACC_RESET = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [7:0]       in_b,
   input  logic             in_load,
   input  logic [REP_W-1:0] in_rep,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_sel,
   input  logic [7:0]       alu_result,
   input  logic             alu_carry,
   input  logic             alu_zero,
   input  logic             alu_negative,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_acc,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_negative,
   output logic [7:0]       instr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       acc_q, acc_d;
   logic [7:0]       b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic [REP_W-1:0] iter_q, iter_d;
   logic             carry_acc_q, carry_acc_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             negative_q, negative_d;
   logic [7:0]       count_q, count_d;

   // Only the add/sub/inc/dec group (ops 0..3) produces a meaningful carry.
   logic             op_uses_carry;
   assign op_uses_carry = (op_q[3:2] == 2'b00);

   // Register update with synchronous reset; a reset mid-instruction simply
   // drops it, so no result is ever presented for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= ACC_RESET;
         b_q         <= '0;
         op_q        <= '0;
         iter_q      <= '0;
         carry_acc_q <= 1'b0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         b_q         <= b_d;
         op_q        <= op_d;
         iter_q      <= iter_d;
         carry_acc_q <= carry_acc_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         negative_q  <= negative_d;
         count_q     <= count_d;
      end
   end

   // Next-state and datapath updates; everything holds unless a state acts.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      b_d         = b_q;
      op_d        = op_q;
      iter_d      = iter_q;
      carry_acc_d = carry_acc_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      negative_d  = negative_q;
      count_d     = count_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in_load) begin
                  // Load bypasses the ALU; carry is deliberately left alone.
                  acc_d      = in_b;
                  zero_d     = (in_b == 8'h00);
                  negative_d = in_b[7];
                  state_d    = DONE;
               end else begin
                  op_d        = in_op;
                  b_d         = in_b;
                  iter_d      = in_rep;
                  carry_acc_d = 1'b0;
                  state_d     = EXEC;
               end
            end
         end
         EXEC: begin
            acc_d      = alu_result;
            zero_d     = alu_zero;
            negative_d = alu_negative;
            if (op_uses_carry) begin
               // Carry is sticky across the iterations of one instruction.
               carry_acc_d = carry_acc_q | alu_carry;
               carry_d     = carry_acc_q | alu_carry;
            end
            if (iter_q == '0) begin
               state_d = DONE;
            end else begin
               iter_d = iter_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               count_d = count_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign alu_a        = acc_q;
   assign alu_b        = b_q;
   assign alu_sel      = op_q;
   assign out_acc      = acc_q;
   assign out_carry    = carry_q;
   assign out_zero     = zero_q;
   assign out_negative = negative_q;
   assign instr_count  = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU attached.
module tb_alu_op_sequencer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [7:0] in_b;
   logic       in_load;
   logic [2:0] in_rep;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_zero;
   logic       alu_negative;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_acc;
   logic       out_carry;
   logic       out_zero;
   logic       out_negative;
   logic [7:0] instr_count;

   int errors = 0;
   int checks = 0;

   alu_op_sequencer #(.REP_W(3), .ACC_RESET(8'h00)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_b         (in_b),
      .in_load      (in_load),
      .in_rep       (in_rep),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_carry    (alu_carry),
      .alu_zero     (alu_zero),
      .alu_negative (alu_negative),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_acc      (out_acc),
      .out_carry    (out_carry),
      .out_zero     (out_zero),
      .out_negative (out_negative),
      .instr_count  (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the team ALU: 0 add, 1 sub, 2 inc, 3 dec, 4 and, 5 or,
   // 6 xor, 7 not, 8 shl, 9 shr, 15 compare-equal.
   always_comb begin
      logic [8:0] wide;
      wide = 9'd0;
      case (alu_sel)
         4'd0:  wide = {1'b0, alu_a} + {1'b0, alu_b};
         4'd1:  wide = {1'b0, alu_a} - {1'b0, alu_b};
         4'd2:  wide = {1'b0, alu_a} + 9'd1;
         4'd3:  wide = {1'b0, alu_a} - 9'd1;
         4'd4:  wide = {1'b0, alu_a & alu_b};
         4'd5:  wide = {1'b0, alu_a | alu_b};
         4'd6:  wide = {1'b0, alu_a ^ alu_b};
         4'd7:  wide = {1'b0, ~alu_a};
         4'd8:  wide = {alu_a, 1'b0};
         4'd9:  wide = {alu_a[0], 1'b0, alu_a[7:1]};
         4'd15: wide = {8'd0, (alu_a == alu_b)};
         default: wide = 9'd0;
      endcase
      alu_result   = wide[7:0];
      alu_carry    = wide[8];
      alu_zero     = (wide[7:0] == 8'h00);
      alu_negative = wide[7];
   end

   // Offer one instruction from posedge+1; returns posedge+1 after the accept edge.
   task automatic send(input logic ld, input logic [3:0] op, input logic [7:0] b,
                       input logic [2:0] rep);
      in_valid = 1'b1;
      in_load  = ld;
      in_op    = op;
      in_b     = b;
      in_rep   = rep;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Bounded wait for out_valid, checking the cycle count from the accept edge.
   task automatic wait_done(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n !== exp_cycles || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles (out_valid=%b), expected %0d",
                  name, n, out_valid, exp_cycles);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s in_ready with out_valid: got %b, expected 0", name, in_ready);
      end
   endtask

   task automatic check_result(input string name, input logic [7:0] acc,
                               input logic c, input logic z, input logic n);
      checks++;
      if (out_acc !== acc || out_carry !== c || out_zero !== z || out_negative !== n) begin
         errors++;
         $display("FAIL %s result: got acc=%h c=%b z=%b n=%b, expected acc=%h c=%b z=%b n=%b",
                  name, out_acc, out_carry, out_zero, out_negative, acc, c, z, n);
      end
   endtask

   task automatic accept(input string name, input logic [7:0] exp_count);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || instr_count !== exp_count) begin
         errors++;
         $display("FAIL %s handshake: got in_ready=%b out_valid=%b count=%0d, expected 1 0 %0d",
                  name, in_ready, out_valid, instr_count, exp_count);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset handshake: got in_ready=%b out_valid=%b, expected 1 0",
                  in_ready, out_valid);
      end
      check_result("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (instr_count !== 8'd0 || alu_sel !== 4'd0 || alu_b !== 8'd0 || alu_a !== 8'd0) begin
         errors++;
         $display("FAIL reset regs: got count=%0d sel=%h b=%h a=%h, expected all 0",
                  instr_count, alu_sel, alu_b, alu_a);
      end
   endtask

   task automatic test_load;
      send(1'b1, 4'd0, 8'h0F, 3'd0);
      wait_done("load0F", 0);
      check_result("load0F", 8'h0F, 1'b0, 1'b0, 1'b0);
      accept("load0F", 8'd1);
   endtask

   task automatic test_add;
      send(1'b0, 4'd0, 8'h01, 3'd0);
      wait_done("add", 1);
      check_result("add", 8'h10, 1'b0, 1'b0, 1'b0);
      accept("add", 8'd2);
   endtask

   task automatic test_logic_ops;
      send(1'b1, 4'd0, 8'h81, 3'd0);
      wait_done("load81", 0);
      check_result("load81", 8'h81, 1'b0, 1'b0, 1'b1);
      accept("load81", 8'd3);
      // Shift-out carry from the ALU is 1 here but must not reach the flag.
      send(1'b0, 4'd8, 8'h00, 3'd0);
      wait_done("shl", 1);
      check_result("shl", 8'h02, 1'b0, 1'b0, 1'b0);
      accept("shl", 8'd4);
      send(1'b0, 4'd6, 8'h02, 3'd0);
      wait_done("xor", 1);
      check_result("xor", 8'h00, 1'b0, 1'b1, 1'b0);
      accept("xor", 8'd5);
   endtask

   task automatic test_repeat_inc;
      send(1'b1, 4'd0, 8'hFE, 3'd0);
      wait_done("loadFE", 0);
      accept("loadFE", 8'd6);
      send(1'b0, 4'd2, 8'h00, 3'd2);
      checks++;
      if (alu_sel !== 4'd2 || alu_a !== 8'hFE) begin
         errors++;
         $display("FAIL inc exec1 drive: got sel=%h a=%h, expected 2 fe", alu_sel, alu_a);
      end
      @(posedge clk); #1;
      checks++;
      if (alu_a !== 8'hFF || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL inc exec2 acc: got a=%h ov=%b ir=%b, expected ff 0 0",
                  alu_a, out_valid, in_ready);
      end
      wait_done("inc3", 2);
      check_result("inc3", 8'h01, 1'b1, 1'b0, 1'b0);
      accept("inc3", 8'd7);
      // Load must leave the sticky carry untouched.
      send(1'b1, 4'd0, 8'h80, 3'd0);
      wait_done("load80", 0);
      check_result("load80", 8'h80, 1'b1, 1'b0, 1'b1);
      accept("load80", 8'd8);
   endtask

   task automatic test_backpressure;
      send(1'b0, 4'd4, 8'h00, 3'd1);
      wait_done("and_bp", 2);
      check_result("and_bp", 8'h00, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_load  = 1'b1;
         in_b     = 8'h55;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 8'h00 ||
             instr_count !== 8'd8) begin
            errors++;
            $display("FAIL backpressure cycle %0d: got ov=%b ir=%b acc=%h count=%0d, expected 1 0 00 8",
                     i, out_valid, in_ready, out_acc, instr_count);
         end
      end
      in_valid = 1'b0;
      accept("and_bp", 8'd9);
      // Arithmetic op replaces the old carry with this instruction's own.
      send(1'b0, 4'd0, 8'h01, 3'd0);
      wait_done("add_clr", 1);
      check_result("add_clr", 8'h01, 1'b0, 1'b0, 1'b0);
      accept("add_clr", 8'd10);
   endtask

   task automatic test_reset_mid_exec;
      int seen;
      send(1'b0, 4'd0, 8'h01, 3'd7);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || instr_count !== 8'd0) begin
         errors++;
         $display("FAIL abort state: got ir=%b ov=%b count=%0d, expected 1 0 0",
                  in_ready, out_valid, instr_count);
      end
      check_result("abort", 8'h00, 1'b0, 1'b0, 1'b0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort no result: out_valid seen %0d cycles, expected 0", seen);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_load   = 1'b0;
      in_op     = 4'd0;
      in_b      = 8'd0;
      in_rep    = 3'd0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_load();
      test_add();
      test_logic_ops();
      test_repeat_inc();
      test_backpressure();
      test_reset_mid_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
